// File: rtl/fifo_ms_arb.sv
// Multi-stream FIFO: one tagged write port feeds FLUX circular buffers, one arbitrated read port.
// Define FIFO_MS_ARB_RR_EN to select round-robin arbitration instead of fixed lowest-index priority.
module fifo_ms_arb #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                      ck,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic [WIDTH-1:0]          datain,
    input  logic [FLUX-1:0]           rd,
    output logic                      wr_ack,
    output logic [FLUX-1:0]           rd_gnt,
    output logic [WIDTH-1:0]          dataout,
    output logic                      dout_valid,
    output logic [TAG_WIDTH-1:0]      dout_ch,
    output logic [FLUX-1:0]           full,
    output logic [FLUX-1:0]           empty,
    output logic [FLUX*CNT_WIDTH-1:0] level,
    output logic [FLUX-1:0]           overflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [TAG_WIDTH:0]   FLUX_TAG  = (TAG_WIDTH + 1)'(FLUX);

    logic [WIDTH-1:0]      mem [FLUX][DEPTH];
    logic [ADDR_WIDTH-1:0] wp_reg [FLUX];
    logic [ADDR_WIDTH-1:0] rp_reg [FLUX];
    logic [CNT_WIDTH-1:0]  cnt_reg [FLUX];
    logic [FLUX-1:0]       overflow_reg;
    logic [WIDTH-1:0]      dataout_reg;
    logic                  dout_valid_reg;
    logic [TAG_WIDTH-1:0]  dout_ch_reg;

    logic [TAG_WIDTH-1:0]  tag;
    logic                  tag_ok;
    logic [FLUX-1:0]       eligible;
    logic [FLUX-1:0]       wr_hit;
    logic [FLUX-1:0]       ovf_hit;
    logic                  gnt_any;
    logic [TAG_WIDTH-1:0]  gnt_idx;

    assign tag    = datain[WIDTH-1 -: TAG_WIDTH];
    // Tags beyond the last channel (non-power-of-two FLUX) are silently dropped.
    assign tag_ok = {1'b0, tag} < FLUX_TAG;

    generate
        for (genvar gi = 0; gi < FLUX; gi++) begin : g_ch
            assign full[gi]     = (cnt_reg[gi] == DEPTH_CNT);
            assign empty[gi]    = (cnt_reg[gi] == '0);
            assign level[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg[gi];
            assign eligible[gi] = rd[gi] & ~empty[gi];
            assign wr_hit[gi]   = wr_ack & (tag == TAG_WIDTH'(gi));
            assign ovf_hit[gi]  = wr & tag_ok & ~wr_ack & (tag == TAG_WIDTH'(gi));
        end
    endgenerate

`ifdef FIFO_MS_ARB_RR_EN
    logic [FLUX-1:0] last_gnt_reg;

    // Search begins one past the last winner; descending scan lets the nearest candidate win.
    always_comb begin
        int start;
        int idx;
        start   = 0;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (last_gnt_reg[i]) start = (i + 1) % FLUX;
        end
        for (int k = FLUX - 1; k >= 0; k--) begin
            idx = (start + k) % FLUX;
            if (eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= {1'b1, {(FLUX-1){1'b0}}};
        end else if (gnt_any) begin
            last_gnt_reg <= rd_gnt;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        rd_gnt = '0;
        if (gnt_any) rd_gnt[gnt_idx] = 1'b1;
    end

    // A full channel still accepts when it is popped in the same cycle.
    assign wr_ack = wr & tag_ok & (~full[tag] | rd_gnt[tag]);

    always_ff @(posedge ck) begin
        if (wr_ack) mem[tag][wp_reg[tag]] <= datain;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FLUX; i++) begin
                wp_reg[i]  <= '0;
                rp_reg[i]  <= '0;
                cnt_reg[i] <= '0;
            end
            overflow_reg   <= '0;
            dataout_reg    <= '0;
            dout_valid_reg <= 1'b0;
            dout_ch_reg    <= '0;
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                if (wr_hit[i]) wp_reg[i] <= wp_reg[i] + 1'b1;
                if (rd_gnt[i]) rp_reg[i] <= rp_reg[i] + 1'b1;
                if (wr_hit[i] && !rd_gnt[i]) begin
                    cnt_reg[i] <= cnt_reg[i] + 1'b1;
                end else if (!wr_hit[i] && rd_gnt[i]) begin
                    cnt_reg[i] <= cnt_reg[i] - 1'b1;
                end
                if (ovf_hit[i]) overflow_reg[i] <= 1'b1;
            end
            dout_valid_reg <= gnt_any;
            if (gnt_any) begin
                dataout_reg <= mem[gnt_idx][rp_reg[gnt_idx]];
                dout_ch_reg <= gnt_idx;
            end
        end
    end

    assign overflow   = overflow_reg;
    assign dataout    = dataout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_ch    = dout_ch_reg;

endmodule
